// File: rtl/dijkstra_min_sched_if.sv
// Custom-instruction and comparator signal bundle
// for the Dijkstra frontier-minimum controller.
interface dijkstra_min_sched_if;
  logic        start;
  logic [1:0]  n;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic        done;
  logic [31:0] result;
  logic [31:0] cmp_dataa;
  logic [31:0] cmp_datab;
  logic        cmp_start;
  logic [31:0] cmp_result;

  modport slave (
    input  start, n, dataa, datab, cmp_result,
    output done, result, cmp_dataa, cmp_datab, cmp_start
  );

  modport master (
    output start, n, dataa, datab, cmp_result,
    input  done, result, cmp_dataa, cmp_datab, cmp_start
  );
endinterface

// File: rtl/dijkstra_min_sched.sv
// Nios multicycle custom instruction tracking the running
// minimum (distance, node) via a shared float <= comparator.
module dijkstra_min_sched #(
  parameter int unsigned CMP_LATENCY = 1,
  parameter logic [31:0] INF_WORD    = 32'h7F800000
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_en,
  dijkstra_min_sched_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT, DECIDE, FINISH
  } state_t;

  localparam logic [1:0] OP_CLR  = 2'd0;
  localparam logic [1:0] OP_PUSH = 2'd1;
  localparam logic [1:0] OP_RMIN = 2'd2;
  localparam logic [1:0] OP_RIDX = 2'd3;

  localparam logic [3:0] CNT_INIT =
    (CMP_LATENCY == 0) ? 4'd0 : 4'(CMP_LATENCY - 1);

  state_t      st, st_nx;
  logic [1:0]  op;
  logic [31:0] cand_dist, cand_idx;
  logic [31:0] min_dist, min_idx;
  logic [3:0]  cnt;
  logic        upd;
  logic        cand_nan;
  logic        done_q, done_d;
  logic        cs_q, cs_d;
  logic [31:0] res_q, res_d;
  logic [31:0] ca_q, ca_d;
  logic [31:0] cb_q, cb_d;
  logic        unused_cmp_hi;

  assign cand_nan = (&bus.dataa[30:23]) && (|bus.dataa[22:0]);
  assign unused_cmp_hi = ^bus.cmp_result[31:1];

  assign bus.done      = done_q;
  assign bus.result    = res_q;
  assign bus.cmp_start = cs_q;
  assign bus.cmp_dataa = ca_q;
  assign bus.cmp_datab = cb_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= IDLE;
      op        <= OP_CLR;
      cand_dist <= '0;
      cand_idx  <= '0;
      min_dist  <= INF_WORD;
      min_idx   <= '1;
      cnt       <= '0;
      upd       <= 1'b0;
      done_q    <= 1'b0;
      cs_q      <= 1'b0;
      res_q     <= '0;
      ca_q      <= '0;
      cb_q      <= '0;
    end else if (clk_en) begin
      st     <= st_nx;
      done_q <= done_d;
      cs_q   <= cs_d;
      res_q  <= res_d;
      ca_q   <= ca_d;
      cb_q   <= cb_d;
      unique case (st)
        IDLE: if (bus.start) begin
          op        <= bus.n;
          cand_dist <= bus.dataa;
          cand_idx  <= bus.datab;
          upd       <= 1'b0;
        end
        LAUNCH: cnt <= CNT_INIT;
        WAIT:   cnt <= cnt - 4'd1;
        // comparator says min <= cand; only a strict win replaces
        DECIDE: if (!bus.cmp_result[0]) begin
          min_dist <= cand_dist;
          min_idx  <= cand_idx;
          upd      <= 1'b1;
        end
        FINISH: if (op == OP_CLR) begin
          min_dist <= INF_WORD;
          min_idx  <= '1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE: if (bus.start) begin
        if (bus.n == OP_PUSH && !cand_nan)
          st_nx = LAUNCH;
        else
          st_nx = FINISH;
      end
      LAUNCH: st_nx = (CMP_LATENCY == 0) ? DECIDE : WAIT;
      WAIT:   if (cnt == 4'd0) st_nx = DECIDE;
      DECIDE: st_nx = FINISH;
      FINISH: st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_comb begin
    done_d = 1'b0;
    cs_d   = 1'b0;
    res_d  = res_q;
    ca_d   = ca_q;
    cb_d   = cb_q;
    if (st == LAUNCH) begin
      cs_d = 1'b1;
      ca_d = min_dist;
      cb_d = cand_dist;
    end
    if (st == FINISH) begin
      done_d = 1'b1;
      unique case (1'b1)
        (op == OP_CLR):  res_d = '0;
        (op == OP_PUSH): res_d = {31'd0, upd};
        (op == OP_RMIN): res_d = min_dist;
        (op == OP_RIDX): res_d = min_idx;
        default:         res_d = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dijkstra_min_sched.sv
// Randomized self-checking bench for dijkstra_min_sched
// against an ordered-key float minimum model.
module tb_dijkstra_min_sched;

  localparam int LAT = 3;
  localparam logic [31:0] INF = 32'h7F800000;

  logic clk = 1'b0;
  logic reset;
  logic clk_en;
  int   npass = 0;
  int   ntot  = 0;
  int   cs_cnt = 0;
  logic [LAT-1:0] cpipe = '0;
  logic [31:0] ref_min = INF;
  logic [31:0] ref_idx = 32'hFFFFFFFF;

  dijkstra_min_sched_if bus ();

  dijkstra_min_sched #(
    .CMP_LATENCY(LAT),
    .INF_WORD(INF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clk_en(clk_en),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fkey(logic [31:0] a);
    return a[31] ? ~a : (a | 32'h80000000);
  endfunction

  function automatic bit fle(logic [31:0] a, logic [31:0] b);
    if (a[30:0] == 0 && b[30:0] == 0) return 1'b1;
    return fkey(a) <= fkey(b);
  endfunction

  function automatic bit is_nan(logic [31:0] a);
    return a[30:23] == 8'hFF && a[22:0] != 0;
  endfunction

  // comparator with LAT-cycle latency; junk bits when no launch
  always @(posedge clk)
    if (clk_en)
      cpipe <= {cpipe[LAT-2:0],
                bus.cmp_start ? fle(bus.cmp_dataa, bus.cmp_datab)
                              : 1'($urandom)};

  assign bus.cmp_result = {31'h2AAAAAAA, cpipe[LAT-1]};

  always @(posedge clk)
    if (clk_en && bus.cmp_start) cs_cnt <= cs_cnt + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model(input logic [1:0] op,
                       input logic [31:0] a, b,
                       output logic [31:0] exp_res,
                       output bit push_ok);
    push_ok = (op == 2'd1) && !is_nan(a);
    exp_res = '0;
    case (op)
      2'd0: begin ref_min = INF; ref_idx = '1; end
      2'd1: if (push_ok && !fle(ref_min, a)) begin
        ref_min = a;
        ref_idx = b;
        exp_res = 1;
      end
      2'd2: exp_res = ref_min;
      default: exp_res = ref_idx;
    endcase
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, b);
    bus.start = 1'b1;
    bus.n     = op;
    bus.dataa = a;
    bus.datab = b;
  endtask

  task automatic op_chk(input logic [1:0] op, input logic [31:0] a, b);
    logic [31:0] exp_res, old_min, res;
    bit push_ok;
    int lat, cs0;
    old_min = ref_min;
    model(op, a, b, exp_res, push_ok);
    cs0 = cs_cnt;
    issue(op, a, b);
    @(negedge clk);
    bus.start = 1'b0;
    bus.dataa = $urandom;
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = bus.result;
    chk("latency", 32'(lat), push_ok ? 32'(4 + LAT) : 32'd2);
    chk("result", res, exp_res);
    chk("cmp_starts", 32'(cs_cnt - cs0), {31'd0, push_ok});
    if (push_ok) begin
      chk("cmp_dataa", bus.cmp_dataa, old_min);
      chk("cmp_datab", bus.cmp_datab, a);
    end
    @(negedge clk);
    chk("done_pulse", {31'd0, bus.done}, 32'd0);
  endtask

  function automatic logic [31:0] rand_f();
    logic [31:0] m;
    m = $urandom;
    case ($urandom_range(0, 9))
      0: return {m[31], 8'hFF, m[22:0] | 23'd1};
      1: return {m[31], 8'hFF, 23'd0};
      2: return {m[31], 31'd0};
      3: return ref_min;
      default: return {m[31], 8'($urandom_range(100, 150)), m[22:0]};
    endcase
  endfunction

  initial begin
    logic [31:0] exp_res, res1;
    bit push_ok;
    int dlat, ndone;

    reset = 1'b1;
    clk_en = 1'b1;
    bus.start = 1'b0;
    bus.n = 2'd0;
    bus.dataa = '0;
    bus.datab = '0;
    repeat (3) @(negedge clk);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_cmp_start", {31'd0, bus.cmp_start}, 32'd0);
    chk("rst_cmp_dataa", bus.cmp_dataa, 32'd0);
    chk("rst_cmp_datab", bus.cmp_datab, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    op_chk(2'd2, 0, 0);
    op_chk(2'd3, 0, 0);
    op_chk(2'd0, 0, 0);
    op_chk(2'd1, 32'h3F800000, 5);
    op_chk(2'd1, 32'h40200000, 7);
    op_chk(2'd3, 0, 0);
    op_chk(2'd2, 0, 0);
    op_chk(2'd1, 32'h3F800000, 9);
    op_chk(2'd3, 0, 0);
    op_chk(2'd1, 32'hC0400000, 2);
    op_chk(2'd2, 0, 0);
    op_chk(2'd1, 32'h7FC00000, 4);
    op_chk(2'd2, 0, 0);

    // clk_en dropped four cycles mid-WAIT stretches done to T+11
    model(2'd1, 32'hC1000000, 11, exp_res, push_ok);
    issue(2'd1, 32'hC1000000, 11);
    dlat = 40;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start = 1'b0;
        chk("cs_at_t1", {31'd0, bus.cmp_start}, 32'd0);
      end
      if (k == 2) chk("cs_at_t2", {31'd0, bus.cmp_start}, 32'd1);
      if (k == 3) clk_en = 1'b0;
      if (k == 7) clk_en = 1'b1;
      if (bus.done) begin
        dlat = k;
        break;
      end
    end
    chk("clken_latency", 32'(dlat), 32'd11);
    chk("clken_result", bus.result, exp_res);
    @(negedge clk);
    chk("clken_done_pulse", {31'd0, bus.done}, 32'd0);
    op_chk(2'd3, 0, 0);

    // reset while waiting on the comparator
    issue(2'd1, 32'hC2000000, 12);
    ndone = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k == 3) reset = 1'b1;
      if (k == 4) reset = 1'b0;
      if (bus.done) ndone++;
    end
    ref_min = INF;
    ref_idx = '1;
    chk("rst_mid_push_done", 32'(ndone), 32'd0);
    op_chk(2'd2, 0, 0);

    // a second start while busy must be dropped
    model(2'd1, 32'h40000000, 21, exp_res, push_ok);
    issue(2'd1, 32'h40000000, 21);
    ndone = 0;
    dlat = 0;
    res1 = '0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k == 2) issue(2'd3, 0, 0);
      if (k == 3) bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        dlat = k;
        res1 = bus.result;
      end
    end
    chk("busy_done_count", 32'(ndone), 32'd1);
    chk("busy_latency", 32'(dlat), 32'(4 + LAT));
    chk("busy_result", res1, exp_res);
    op_chk(2'd3, 0, 0);

    for (int i = 0; i < 150; i++) begin
      int sel;
      sel = $urandom_range(0, 19);
      if (sel < 2) op_chk(2'd0, 0, 0);
      else if (sel < 13) op_chk(2'd1, rand_f(), $urandom);
      else if (sel < 16) op_chk(2'd2, $urandom, $urandom);
      else op_chk(2'd3, $urandom, $urandom);
    end
    op_chk(2'd2, 0, 0);
    op_chk(2'd3, 0, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
